// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM state encoding, the fetch-buffer entry layout and the NOP encoding.
// Entry widths are fixed here; the top-level XLEN/ILEN parameters must match them.
package ifetch_pkg;

  localparam int IF_XLEN = 64;
  localparam int IF_ILEN = 32;

  // addi x0, x0, 0 -- instruction slot of a synthesised misaligned-fetch fault entry
  localparam logic [IF_ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  // IDLE: nothing outstanding, WAIT: one live request, DROP: one request from a flushed path
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ifetch_state_e;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_ILEN-1:0] instr;
    logic               fault;
  } ifetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Fetch buffer: synchronous FIFO of ifetch_entry_t with synchronous clear.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push while full and pop while empty are ignored; clear beats push/pop.
// Ports: clk_i/rst_ni clock and async active-low reset; clr_i flush all entries;
//        push_i/push_dat_i write; pop_i read; head_o head entry; count_o/full_o/empty_o status.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic                         push_i,
  input  ifetch_entry_t                push_dat_i,
  input  logic                         pop_i,
  output ifetch_entry_t                head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  ifetch_entry_t   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: one outstanding imem request, (pc, instr, fault) buffered toward decode.
// Latency: request and address are combinational from pc; an entry reaches id_* the cycle after its response.
// Backpressure: no request unless buffered + outstanding < FIFO_DEPTH; fetch_stall_o holds the PC otherwise.
// Ports: clk_i/rst_ni clock and async active-low reset; pc_i current PC; flush_i redirect;
//        fetch_stall_o PC hold; imem_req_* request channel; imem_resp_* response channel;
//        id_valid_o/id_ready_i/id_pc_o/id_instr_o/id_fault_o decode handshake and head entry.
// Optional build macro IFETCH_MISALIGN_CHK_EN: a misaligned PC yields a fault entry instead of a request.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int XLEN       = IF_XLEN,
  parameter int ILEN       = IF_ILEN,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic            fetch_stall_o,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_resp_valid_i,
  input  logic [ILEN-1:0] imem_resp_data_i,
  input  logic            imem_resp_err_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [ILEN-1:0] id_instr_o,
  output logic            id_fault_o
);

  ifetch_state_e state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  ifetch_entry_t   fifo_head;
  logic            push;
  ifetch_entry_t   push_dat;

  logic            outstanding;
  logic            space;
  logic            resp_slot;
  logic            pc_misaligned;
  logic            misalign_push;
  logic            req_hs;

  assign outstanding = (state_q != IDLE);

  // Registered occupancy only: a pop in this cycle does not free a slot until next cycle.
  assign space = (int'(fifo_count) + int'(outstanding)) < FIFO_DEPTH;

  // A new request may go out when nothing is outstanding, or in the very cycle the
  // outstanding one (live or dropped) returns.
  assign resp_slot = (state_q == IDLE) | imem_resp_valid_i;

`ifdef IFETCH_MISALIGN_CHK_EN
  assign pc_misaligned = (pc_i[1:0] != 2'b00);
`else
  assign pc_misaligned = 1'b0;
`endif

  // A misaligned PC never reaches memory; it becomes a fault entry once the unit is idle.
  assign misalign_push = rst_ni & ~flush_i & space & pc_misaligned & (state_q == IDLE);

  // Gated by rst_ni so the request is quiet while reset is held.
  assign imem_req_valid_o = rst_ni & ~flush_i & space & resp_slot & ~pc_misaligned;
  assign imem_req_addr_o  = pc_i;
  assign req_hs           = imem_req_valid_o & imem_req_ready_i;
  assign fetch_stall_o    = ~req_hs;

  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;
    push_dat = '0;
    case (state_q)
      IDLE: begin
        if (misalign_push) begin
          push     = 1'b1;
          push_dat = '{pc: pc_i, instr: NOP_INSTR, fault: 1'b1};
        end
        if (req_hs) begin
          state_d  = WAIT;
          req_pc_d = pc_i;
        end
      end
      WAIT: begin
        if (flush_i) begin
          // The response, if present, belongs to the squashed path and is dropped here.
          state_d = imem_resp_valid_i ? IDLE : DROP;
        end else if (imem_resp_valid_i) begin
          push     = 1'b1;
          push_dat = '{pc: req_pc_q, instr: imem_resp_data_i, fault: imem_resp_err_i};
          state_d  = req_hs ? WAIT : IDLE;
          if (req_hs) begin
            req_pc_d = pc_i;
          end
        end
      end
      DROP: begin
        // The dropped response retires the outstanding request even under a new flush;
        // staying in DROP then would wait for a response that never comes.
        if (imem_resp_valid_i) begin
          state_d = req_hs ? WAIT : IDLE;
          if (req_hs) begin
            req_pc_d = pc_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (flush_i),
    .push_i     (push & ~fifo_full),
    .push_dat_i (push_dat),
    .pop_i      (id_valid_o & id_ready_i),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign id_valid_o = ~fifo_empty;
  assign id_pc_o    = fifo_head.pc;
  assign id_instr_o = fifo_head.instr;
  assign id_fault_o = fifo_head.fault;

endmodule
